mem_port_arb: RTL and testbench

//  Multi-cycle arbiter/sequencer for the single-port SISC memory. Shares it between instruction

---
 rtl/mem_port_arb_pkg.sv | 23 ++
 rtl/mem_port_arb_starve_cnt.sv | 30 +++
 rtl/mem_port_arb.sv | 145 ++++++++++++++
 tb/tb_mem_port_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the SISC memory-port arbiter.
//   arb_state_t : sequencer states (3-bit encoding)
//   gnt_t       : which requester owns the current access
//   DEF_AW/DW   : default address/data widths (pc/br and ir/rf widths)
package mem_port_arb_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arb_starve_cnt.sv
// Saturating fetch-starvation counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : fetch lost an arbitration round (saturates at LIM)
//   clr      : fetch was granted (takes priority over inc)
//   at_lim   : count has reached LIM, fetch must win the next contended round
module mem_port_arb_starve_cnt #(
  parameter int unsigned LIM = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_lim
);

  logic [3:0] cnt;

  assign at_lim = (cnt == 4'(LIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_lim) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Multi-cycle arbiter/sequencer sharing the single-port SISC memory between
// instruction fetch (if_*) and data load/store (dm_*), one access at a time.
//   clk, rst          : clock, synchronous active-high reset
//   if_req/if_addr    : fetch request, held until if_ack
//   if_ack/if_rdata   : fetch done pulse, fetched word (registered)
//   dm_req/dm_we/dm_addr/dm_wdata : data request, held until dm_ack
//   dm_ack/dm_rdata   : data done pulse, load data (registered)
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobes (registered)
//   mem_rdata         : memory read data, valid MEM_LAT cycles after mem_en
//   busy              : high in every state except IDLE
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  arb_state_t    state;
  gnt_t          gnt;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;
  logic [2:0]    lat_cnt;

  logic at_lim;
  logic dm_wins;
  logic starve_inc;
  logic starve_clr;

  // dm wins any contended round unless fetch has already lost STARVE_LIM in a row
  always_comb begin
    dm_wins    = dm_req && !(if_req && at_lim);
    starve_inc = (state == ST_IDLE) && if_req && dm_wins;
    starve_clr = (state == ST_IDLE) && if_req && !dm_wins;
  end

  mem_port_arb_starve_cnt #(
    .LIM(STARVE_LIM)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_lim(at_lim)
  );

  assign busy = (state != ST_IDLE);

  // Strobes and acks are registered: each is set on the edge entering the
  // state in which it must be visible (mem_en in ISSUE, ack in DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= GNT_IF;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_cnt   <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_req || dm_req) begin
            gnt       <= dm_wins ? GNT_DM : GNT_IF;
            lat_addr  <= dm_wins ? dm_addr : if_addr;
            lat_wdata <= dm_wdata;
            lat_we    <= dm_wins && dm_we;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          mem_addr  <= lat_addr;
          mem_wdata <= lat_wdata;
          mem_we    <= lat_we;
          mem_en    <= 1'b1;
          state     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (lat_we) begin
            dm_ack <= 1'b1;
            state  <= ST_DONE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 3'd0) begin
            if (gnt == GNT_DM) begin
              dm_rdata <= mem_rdata;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            state <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;
  localparam int unsigned LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_port_arb #(
    .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIM(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory responder: data is valid only in the single cycle LAT after mem_en,
  // junk otherwise, so a mistimed capture shows up as bad data.
  logic [31:0] mem [0:65535];
  logic [31:0] pipe [0:LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    pipe[0] <= mem_en ? mem[mem_addr] : $urandom;
    for (int unsigned k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Transaction-level reference model
  logic [31:0] ref_mem [0:65535];
  int unsigned ref_starve;

  task automatic predict(input logic ir, input logic dr, input logic we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [31:0] wd,
                         output logic dm_w, output int unsigned exp_lat, output logic [31:0] exp_rd);
    if (ir && dr) dm_w = (ref_starve != LIM);
    else          dm_w = dr;
    if (ir) ref_starve = dm_w ? ((ref_starve < LIM) ? ref_starve + 1 : LIM) : 0;
    if (dm_w && we) begin
      ref_mem[da] = wd;
      exp_lat = 3;
      exp_rd = '0;
    end else begin
      exp_lat = LAT + 3;
      exp_rd = ref_mem[dm_w ? da : ia];
    end
  endtask

  // Drive one request set in an IDLE cycle, collect what the DUT does until ack.
  task automatic run_txn(input logic ir, input logic dr, input logic we,
                         input logic [15:0] ia, input logic [15:0] da, input logic [31:0] wd,
                         output logic got_if, output logic got_dm, output int lat, output int n_en,
                         output logic [15:0] en_addr, output logic en_we, output logic [31:0] en_wdata,
                         output logic proto_err, output logic [31:0] rd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = we; dm_addr = da; dm_wdata = wd;
    got_if = 0; got_dm = 0; lat = 0; n_en = 0; en_addr = '0; en_we = 0; en_wdata = '0;
    proto_err = 0; rd = '0;
    for (int c = 1; c <= 20 && !(got_if || got_dm); c++) begin
      @(posedge clk); #1;
      if (mem_en) begin n_en++; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata; end
      if (mem_we && !mem_en) proto_err = 1;
      if (if_ack && dm_ack) proto_err = 1;
      if (if_ack) begin got_if = 1; rd = if_rdata; lat = c; end
      if (dm_ack) begin got_dm = 1; rd = dm_rdata; lat = c; end
    end
    if_req = 0; dm_req = 0;
    @(posedge clk); #1;
    if (if_ack || dm_ack || mem_en) proto_err = 1;
  endtask

  task automatic do_txn(input logic ir, input logic dr, input logic we,
                        input logic [15:0] ia, input logic [15:0] da, input logic [31:0] wd,
                        input logic exp_dm, input int unsigned exp_lat, input logic [31:0] exp_rd);
    logic gi, gd, ew, pe;
    int lat, ne;
    logic [15:0] ea;
    logic [31:0] ewd, rd;
    run_txn(ir, dr, we, ia, da, wd, gi, gd, lat, ne, ea, ew, ewd, pe, rd);
    check("one_ack", 32'(gi ^ gd), 32'd1);
    check("winner_dm", 32'(gd), 32'(exp_dm));
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_en_count", 32'(ne), 32'd1);
    check("mem_addr", 32'(ea), 32'(exp_dm ? da : ia));
    check("mem_we", 32'(ew), 32'(exp_dm && we));
    if (exp_dm && we) check("mem_wdata", ewd, wd);
    else              check("rdata", rd, exp_rd);
    check("strobe_rules", 32'(pe), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_dm_ack", 32'(dm_ack), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
  endtask

  typedef struct {
    logic        ir, dr, we;
    logic [15:0] ia, da;
    logic [31:0] wd;
    logic        exp_dm;
    int unsigned exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic        m_dm, r_ir, r_dr, r_we;
    int unsigned m_lat;
    logic [31:0] m_rd, r_wd;
    logic [15:0] r_ia, r_da;
    int          n_ack, ack_cyc;

    rst = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = init_word(16'(i));
      ref_mem[i] = init_word(16'(i));
    end
    mem[4] = 32'h10230005;
    ref_mem[4] = 32'h10230005;
    ref_starve = 0;

    // ir dr we ia da wd exp_dm lat rdata
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 32'h0,        1'b0, 5, 32'h10230005};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 32'hDEADBEEF, 1'b1, 3, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0020, 32'h0,        1'b1, 5, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h0004, 16'h0030, 32'h12345678, 1'b1, 3, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0030, 32'h0,        1'b1, 5, 32'h12345678};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 16'h0004, 16'h0040, 32'h11111111, 1'b0, 5, 32'h10230005};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0020, 32'h0,        1'b1, 5, 32'hDEADBEEF};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 16'h0004, 16'h0050, 32'hAAAA5555, 1'b1, 3, 32'h0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 16'h0004, 16'h0050, 32'h0,        1'b1, 5, 32'hAAAA5555};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 16'h0008, 16'h0020, 32'h0,        1'b0, 5, 32'h5A52FFF7};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 0;
    @(posedge clk); #1;

    // Single fetch, single store, then held contention dm,dm,dm,if,dm,dm,dm,if
    foreach (tbl[i]) begin
      predict(tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].ia, tbl[i].da, tbl[i].wd, m_dm, m_lat, m_rd);
      do_txn(tbl[i].ir, tbl[i].dr, tbl[i].we, tbl[i].ia, tbl[i].da, tbl[i].wd,
             tbl[i].exp_dm, tbl[i].exp_lat, tbl[i].exp_rd);
    end

    // Reset while a load is in WAIT with lat_cnt == 1
    dm_req = 1; dm_we = 0; dm_addr = 16'h0020;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1; dm_req = 0;
    @(posedge clk); #1;
    rst = 0;
    check_reset_outputs();
    ref_starve = 0;
    n_ack = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (dm_ack || if_ack) n_ack++;
    end
    check("rst_abort_no_ack", 32'(n_ack), 32'd0);
    predict(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 32'h0, m_dm, m_lat, m_rd);
    do_txn(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 32'h0, m_dm, m_lat, m_rd);

    // Protocol violation: dm_req dropped during GRANT
    dm_req = 1; dm_we = 1; dm_addr = 16'h0060; dm_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dm_req = 0;
    n_ack = 0; ack_cyc = 0;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk); #1;
      if (dm_ack) begin n_ack++; ack_cyc = c; end
      if (if_ack) n_ack += 100;
    end
    check("viol_ack_count", 32'(n_ack), 32'd1);
    check("viol_ack_cycle", 32'(ack_cyc), 32'd3);
    check("viol_store", mem[16'h0060], 32'hCAFEF00D);
    check("viol_idle", 32'(busy), 32'd0);
    ref_mem[16'h0060] = 32'hCAFEF00D;

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      r_ir = 1'($urandom_range(0, 1));
      r_dr = 1'($urandom_range(0, 1));
      if (!r_ir && !r_dr) r_ir = 1;
      r_we = 1'($urandom_range(0, 1));
      r_ia = 16'($urandom_range(0, 255));
      r_da = 16'($urandom_range(0, 255));
      r_wd = $urandom;
      predict(r_ir, r_dr, r_we, r_ia, r_da, r_wd, m_dm, m_lat, m_rd);
      do_txn(r_ir, r_dr, r_we, r_ia, r_da, r_wd, m_dm, m_lat, m_rd);
    end

    check("sweep_finished", 32'({sweep[0].done_f, sweep[1].done_f}), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // MEM_LAT = 1 and 7: back-to-back held fetch from 0000..0003
  for (genvar g = 0; g < 2; g++) begin : sweep
    localparam int unsigned SL = (g == 0) ? 1 : 7;

    logic          s_rst, s_if_req, s_if_ack, s_dm_ack, s_mem_en, s_mem_we, s_busy;
    logic [AW-1:0] s_if_addr, s_mem_addr;
    logic [DW-1:0] s_if_rdata, s_dm_rdata, s_mem_wdata, s_mem_rdata;
    logic          done_f = 1'b0;
    logic [31:0]   s_pipe [0:SL-1];

    mem_port_arb #(
      .AW(AW), .DW(DW), .MEM_LAT(SL), .STARVE_LIM(LIM)
    ) u_dut (
      .clk(clk), .rst(s_rst),
      .if_req(s_if_req), .if_addr(s_if_addr), .if_ack(s_if_ack), .if_rdata(s_if_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(32'h0),
      .dm_ack(s_dm_ack), .dm_rdata(s_dm_rdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(s_mem_rdata), .busy(s_busy)
    );

    always @(posedge clk) begin
      s_pipe[0] <= s_mem_en ? init_word(s_mem_addr) : $urandom;
      for (int unsigned k = 1; k < SL; k++) s_pipe[k] <= s_pipe[k-1];
    end
    assign s_mem_rdata = s_pipe[SL-1];

    initial begin
      int  c, idle, stray;
      logic got;
      s_rst = 1; s_if_req = 0; s_if_addr = '0;
      stray = 0;
      repeat (3) @(posedge clk);
      #1;
      s_rst = 0;
      s_if_req = 1;
      for (int k = 0; k < 4; k++) begin
        c = 0; idle = 0; got = 0;
        while (!got && c < 40) begin
          @(posedge clk); #1;
          c++;
          if (!s_busy) idle++;
          if (s_dm_ack || s_mem_we) stray++;
          if (s_if_ack) got = 1;
        end
        check("sweep_latency", 32'(c), 32'((k == 0) ? SL + 3 : SL + 4));
        check("sweep_idle_gap", 32'(idle), 32'((k == 0) ? 0 : 1));
        check("sweep_rdata", s_if_rdata, init_word(16'(k)));
        s_if_addr = 16'(k + 1);
      end
      s_if_req = 0;
      check("sweep_no_dm", 32'(stray), 32'd0);
      check("sweep_dm_rdata", s_dm_rdata, 32'd0);
      check("sweep_mem_wdata", s_mem_wdata, 32'd0);
      done_f = 1'b1;
    end
  end

endmodule
